prbs_gen_chk: RTL
=================

// Module: prbs_gen_chk
// PURPOSE
//  Parametrised Fibonacci LFSR PRBS generator plus self-synchronising PRBS checker.
//  Generator supplies test patterns to link/datapath BIST. Checker locks onto a received bit stream,
//  counts bit errors, and detects loss of lock. Both use the same polynomial.
//  Also provides seed load, step enable and all-zero lockup recovery.
// PARAMETERS
//  WIDTH       16       LFSR length in bits (>=3)
//  TAPS        16'hD008 feedback mask, bit i set = state[i] is a tap (default x^16+x^15+x^13+x^4+1)
//  SEED        1        value used at reset and for lockup recovery (must be nonzero)
//  ERR_CNT_W   16       width of the saturating error counter
//  LOSS_THRESH 4        error tally at which the checker drops lock
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst_n      in   1          synchronous reset, active low
//  en         in   1          advance generator one step
//  load       in   1          load seed_in into generator
//  seed_in    in   WIDTH      seed value for load
//  state      out  WIDTH      generator register
//  prbs_out   out  1          current generator output bit = ^(state & TAPS), combinational
//  lockup     out  1          1-cycle pulse: zero seed replaced by SEED
//  chk_valid  in   1          chk_bit is valid this cycle
//  chk_bit    in   1          received PRBS bit
//  clr_cnt    in   1          clear err_cnt
//  locked     out  1          checker in LOCKED state
//  err        out  1          1-cycle pulse: last checked bit mismatched
//  err_cnt    out  ERR_CNT_W  saturating error count
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=SEED; lockup=0; locked=0; err=0; err_cnt=0.
//   - Checker enters SYNC with fill count 0, chk_reg=0 and miss count 0.
//  Generator:
//   - fb = ^(state & TAPS).
//   - en=1: state <= {state[WIDTH-2:0], fb}. prbs_out is the bit shifted in.
//   - load=1: state <= seed_in. load has priority over en.
//   - load with seed_in==0: state <= SEED and lockup pulses the next cycle.
//   - en=0 and load=0: state holds.
//  Checker FSM (chk_state_e: SYNC, LOCKED). All actions below occur only on cycles with chk_valid=1.
//   - SYNC:
//     - chk_reg <= {chk_reg[WIDTH-2:0], chk_bit}; fill count++.
//     - When fill reaches WIDTH, move to LOCKED if the shifted chk_reg is nonzero.
//     - If that chk_reg is zero, restart fill at 0 and stay in SYNC (idle-zero guard).
//     - err is never asserted in SYNC.
//   - LOCKED:
//     - exp = ^(chk_reg & TAPS).
//     - chk_reg <= {chk_reg[WIDTH-2:0], exp}. The predicted bit is shifted in, not the received bit, so errors do not propagate.
//     - If chk_bit != exp: err=1 next cycle, err_cnt++, miss count++.
//     - Miss count clears after WIDTH consecutive good bits.
//     - When miss count reaches LOSS_THRESH: go to SYNC, locked=0 next cycle, fill=0, chk_reg=0.
//  Latency: err, err_cnt and locked are registered, one cycle after the chk_valid sample.
//  err_cnt:
//   - Saturates at all-ones with no wrap.
//   - clr_cnt=1 forces 0, even if an error occurs in the same cycle.
//   - err_cnt is not cleared by lock loss.
//  chk_valid=0: checker holds all state, err=0.
//  rst_n mid-stream: aborts sync or lock immediately and returns to the reset values above.
// STRUCTURE
//  Package lfsr_pkg:
//   - chk_state_e typedef.
//   - Function lfsr_step(state, taps) returning the next state.
//   - Function lfsr_fb(state, taps).
//  Sub-module prbs_checker holds the FSM, chk_reg, counters and err/err_cnt/locked.
//  The generator stays inline in the top module.
// TESTING (WIDTH=4, TAPS=4'b1100, SEED=1 unless stated)
//  1. Reset then en=1 for 15 cycles -> prbs_out = 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1; state returns to 4'b0001.
//  2. load=1 with seed_in=0 -> state=4'b0001, lockup=1 for exactly one cycle. load+en both 1 with seed_in=4'b1010 -> state=4'b1010.
//  3. Loop prbs_out to chk_bit with chk_valid=en=1 -> locked=1 after 4 valid bits; err_cnt stays 0 for 100 cycles.
//  4. While locked, flip one bit -> exactly one err pulse, err_cnt=1, locked stays 1.
//  5. Feed random bits after lock -> locked=0 once 4 misses accrue; re-feeding clean PRBS relocks in 4 bits.
//  6. All-zero input -> never locks. ERR_CNT_W=2 with 5 errors -> err_cnt saturates at 3. clr_cnt and an error in the same cycle -> err_cnt=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR types and helpers for the PRBS generator and checker.
// Functions work on a 64-bit container; callers zero-extend and truncate to their own width.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    function automatic logic lfsr_fb(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return ^(state & taps);
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        mask = (width >= LFSR_MAX_W) ? '1
             : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
        return {state[LFSR_MAX_W-2:0], lfsr_fb(state, taps)} & mask;
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills from the received stream, then free-runs on its own prediction.
// err/err_cnt/locked are registered one cycle after the chk_valid sample; chk_valid=0 holds all state.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] TAPS        = 16'hD008,
    parameter int               ERR_CNT_W   = 16,
    parameter int               LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_valid,
    input  logic                 chk_bit,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    chk_state_e        chk_state;
    logic [WIDTH-1:0]  chk_reg;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] good_run;
    logic [MISS_W-1:0] miss;
    logic              exp_bit;
    logic [WIDTH-1:0]  rx_shift;
    logic [WIDTH-1:0]  exp_shift;
    logic              mismatch;

    assign exp_bit   = lfsr_fb(LFSR_MAX_W'(chk_reg), LFSR_MAX_W'(TAPS));
    assign rx_shift  = {chk_reg[WIDTH-2:0], chk_bit};
    assign exp_shift = {chk_reg[WIDTH-2:0], exp_bit};
    assign mismatch  = chk_valid && (chk_state == LOCKED) && (chk_bit != exp_bit);
    assign locked    = (chk_state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_state <= SYNC;
            chk_reg   <= '0;
            fill      <= '0;
            good_run  <= '0;
            miss      <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err <= mismatch;
            if (clr_cnt)
                err_cnt <= '0;
            else if (mismatch && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            if (chk_valid) begin
                case (chk_state)
                    SYNC: begin
                        chk_reg <= rx_shift;
                        if (fill == FILL_W'(WIDTH - 1)) begin
                            // An all-zero window is an idle line, not a PRBS: refill instead of locking.
                            fill <= '0;
                            if (rx_shift != '0) begin
                                chk_state <= LOCKED;
                                good_run  <= '0;
                                miss      <= '0;
                            end
                        end else begin
                            fill <= fill + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!mismatch) begin
                            chk_reg <= exp_shift;
                            if (good_run == FILL_W'(WIDTH - 1)) begin
                                good_run <= '0;
                                miss     <= '0;
                            end else begin
                                good_run <= good_run + 1'b1;
                            end
                        end else if (miss == MISS_W'(LOSS_THRESH - 1)) begin
                            chk_state <= SYNC;
                            chk_reg   <= '0;
                            fill      <= '0;
                            good_run  <= '0;
                            miss      <= '0;
                        end else begin
                            chk_reg  <= exp_shift;
                            good_run <= '0;
                            miss     <= miss + 1'b1;
                        end
                    end
                    default: chk_state <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// Fibonacci LFSR PRBS generator with seed load and zero-seed recovery, plus the PRBS checker.
// Generator state updates on the clock after en/load; prbs_out is combinational from state.
module prbs_gen_chk
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] TAPS        = 16'hD008,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter int               ERR_CNT_W   = 16,
    parameter int               LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     seed_in,
    output logic [WIDTH-1:0]     state,
    output logic                 prbs_out,
    output logic                 lockup,
    input  logic                 chk_valid,
    input  logic                 chk_bit,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    assign prbs_out = lfsr_fb(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= SEED;
            lockup <= 1'b0;
        end else begin
            lockup <= 1'b0;
            if (load) begin
                // A zero seed would freeze the LFSR forever; substitute SEED and flag it.
                if (seed_in == '0) begin
                    state  <= SEED;
                    lockup <= 1'b1;
                end else begin
                    state <= seed_in;
                end
            end else if (en) begin
                state <= WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), WIDTH));
            end
        end
    end

    prbs_checker #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .ERR_CNT_W   (ERR_CNT_W),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .chk_valid (chk_valid),
        .chk_bit   (chk_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

endmodule
